fetch_ctrl: RTL and testbench

Fetch sequencer that owns the architectural fetch PC and drives the combinational fetch stage. It presents a PC to fetch each cycle and captures the returned instruction bytes and length into a 2-entry instruction queue toward decode. It resolves unconditional `JMP rel32` (0xE9) locally and accepts late redirects from execute. It also sequences `HLT` (0xF4) into a terminal halted state.

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/fetch_ctrl_if.sv | 27 ++
 rtl/fetch_queue.sv | 85 ++++++++
 rtl/fetch_ctrl.sv | 105 ++++++++++
 tb/tb_fetch_ctrl.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer: opcodes, FSM states,
// instruction-queue entry layout and the JMP rel32 target helper.
package fetch_pkg;

    localparam logic [7:0] OP_JMP = 8'hE9;
    localparam logic [7:0] OP_HLT = 8'hF4;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_e;

    typedef struct packed {
        logic [39:0] instr;
        logic [31:0] pc;
        logic [2:0]  len;
    } q_entry_t;

    localparam int unsigned Q_ENTRY_W = $bits(q_entry_t);

    // rel32 is relative to the end of the 5-byte JMP; the sum wraps mod 2^32
    function automatic logic [31:0] jmp_target(input logic [31:0] pc, input logic [39:0] instr);
        return pc + 32'd5 + instr[39:8];
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-stage, redirect and decode-side signals of the fetch sequencer.
interface fetch_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      fs_pc;
    logic [39:0]      fs_instr;
    logic [2:0]       fs_length;
    logic             redir_valid;
    logic [31:0]      redir_target;
    logic             dec_valid;
    logic             dec_ready;
    logic [39:0]      dec_instr;
    logic [31:0]      dec_pc;
    logic [2:0]       dec_length;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output fs_pc, dec_valid, dec_instr, dec_pc, dec_length, halted, stall_cnt,
        input  fs_instr, fs_length, redir_valid, redir_target, dec_ready
    );

    modport slave (
        input  fs_pc, dec_valid, dec_instr, dec_pc, dec_length, halted, stall_cnt,
        output fs_instr, fs_length, redir_valid, redir_target, dec_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Two-entry shifting FIFO: slot 0 is always the head, so head outputs come
// straight from a register. Flush wins over push/pop.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned WIDTH = Q_ENTRY_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [1:0]       count,
    output logic             head_valid,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] e0_q, e0_d, e1_q, e1_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             pop_s, push_s;

    // Next-state of both slots and the occupancy count
    always_comb begin
        pop_s   = pop & (cnt_q != 2'd0);
        push_s  = push & ((cnt_q != 2'd2) | pop_s);
        e0_d    = e0_q;
        e1_d    = e1_q;
        cnt_d   = cnt_q;
        if (flush) begin
            e0_d  = {WIDTH{1'b0}};
            e1_d  = {WIDTH{1'b0}};
            cnt_d = 2'd0;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (cnt_q == 2'd0) begin
                        e0_d = din;
                    end else begin
                        e1_d = din;
                    end
                    cnt_d = cnt_q + 2'd1;
                end
                2'b01: begin
                    e0_d  = e1_q;
                    e1_d  = {WIDTH{1'b0}};
                    cnt_d = cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        e0_d = din;
                    end else begin
                        e0_d = e1_q;
                        e1_d = din;
                    end
                end
                default: begin
                    cnt_d = cnt_q;
                end
            endcase
        end
        valid_d = (cnt_d != 2'd0);
    end

    // Queue storage registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e0_q    <= {WIDTH{1'b0}};
            e1_q    <= {WIDTH{1'b0}};
            cnt_q   <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            e0_q    <= e0_d;
            e1_q    <= e1_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign count      = cnt_q;
    assign head_valid = valid_q;
    assign head       = e0_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, resolves JMP rel32 locally, takes
// execute redirects, sequences HLT into a terminal state and feeds decode.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic         clk,
    input  logic         rst,
    fetch_ctrl_if.master bus
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             halted_q, halted_d;

    logic [1:0]       q_count_s;
    logic             q_valid_s;
    logic [Q_ENTRY_W-1:0] q_head_s;
    q_entry_t         q_din_s, head_s;
    logic             deq_s, can_enq_s, redirect_s, push_s, pop_s;
    logic [7:0]       opcode_s;

    // Enqueue/redirect arbitration and next PC, state and stall count
    always_comb begin
        opcode_s   = bus.fs_instr[7:0];
        deq_s      = q_valid_s & bus.dec_ready;
        can_enq_s  = (state_q == RUN) & ((q_count_s != 2'd2) | deq_s);
        redirect_s = bus.redir_valid & (state_q != HALTED);
        push_s     = can_enq_s & ~redirect_s;
        pop_s      = deq_s & ~redirect_s;
        q_din_s    = '{instr: bus.fs_instr, pc: pc_q, len: bus.fs_length};
        pc_d       = pc_q;
        state_d    = state_q;
        stall_d    = stall_q;

        if (redirect_s) begin
            pc_d    = bus.redir_target;
            state_d = RUN;
        end else if (push_s) begin
            case (opcode_s)
                OP_JMP:  pc_d = jmp_target(pc_q, bus.fs_instr);
                OP_HLT: begin
                    pc_d    = pc_q;
                    state_d = DRAIN;
                end
                default: pc_d = pc_q + {29'd0, bus.fs_length};
            endcase
        end else if ((state_q == DRAIN) && pop_s && (q_count_s == 2'd1)) begin
            // In DRAIN nothing follows the HLT, so emptying the queue retires it
            state_d = HALTED;
        end else begin
            state_d = state_q;
        end

        if ((state_q == RUN) && !redirect_s && !can_enq_s && (stall_q != CNT_MAX)) begin
            stall_d = stall_q + CNT_ONE;
        end else begin
            stall_d = stall_q;
        end
        halted_d = (state_d == HALTED);
    end

    // Controller state, PC and counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= RUN;
            pc_q     <= RESET_PC;
            stall_q  <= {CNT_W{1'b0}};
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            stall_q  <= stall_d;
            halted_q <= halted_d;
        end
    end

    fetch_queue #(.WIDTH(Q_ENTRY_W)) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (push_s),
        .pop        (pop_s),
        .flush      (redirect_s),
        .din        (q_din_s),
        .count      (q_count_s),
        .head_valid (q_valid_s),
        .head       (q_head_s)
    );

    assign head_s         = q_entry_t'(q_head_s);
    assign bus.fs_pc      = pc_q;
    assign bus.dec_valid  = q_valid_s;
    assign bus.dec_instr  = head_s.instr;
    assign bus.dec_pc     = head_s.pc;
    assign bus.dec_length = head_s.len;
    assign bus.halted     = halted_q;
    assign bus.stall_cnt  = stall_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: a behavioural model predicts PC, queue
// contents, state and stall count; queued entries are compared at the head.
module tb_fetch_ctrl;
    import fetch_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    fetch_ctrl_if #(.CNT_W(16)) bus ();

    fetch_ctrl #(.RESET_PC(32'h0000_0000), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    q_entry_t    sb[$];
    logic [31:0] m_pc;
    state_e      m_state;
    logic [15:0] m_stall;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_pc    = 32'h0000_0000;
        m_state = RUN;
        m_stall = 16'd0;
    endtask

    function automatic logic [39:0] plain(input logic [2:0] len);
        logic [31:0] r;
        r = $urandom();
        return {r, 8'h90};
    endfunction

    // One clock: drive inputs, check the head, advance the model, check outputs
    task automatic step(input logic [39:0] instr, input logic [2:0] len,
                        input logic rdy, input logic rv, input logic [31:0] rt);
        q_entry_t h;
        logic deq, red, can_enq;
        bus.fs_instr     = instr;
        bus.fs_length    = len;
        bus.dec_ready    = rdy;
        bus.redir_valid  = rv;
        bus.redir_target = rt;
        check_val("pre_dec_valid", {63'd0, bus.dec_valid}, {63'd0, sb.size() > 0});
        if (sb.size() > 0) begin
            h = sb[0];
            check_val("head_pc", {32'd0, bus.dec_pc}, {32'd0, h.pc});
            check_val("head_instr", {24'd0, bus.dec_instr}, {24'd0, h.instr});
            check_val("head_len", {61'd0, bus.dec_length}, {61'd0, h.len});
        end
        deq     = (sb.size() > 0) && rdy;
        red     = rv && (m_state != HALTED);
        can_enq = (m_state == RUN) && ((sb.size() < 2) || deq);
        if (red) begin
            sb.delete();
            m_pc    = rt;
            m_state = RUN;
        end else begin
            if (m_state == RUN && !can_enq && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
            if (deq) begin
                void'(sb.pop_front());
                if (m_state == DRAIN && sb.size() == 0) m_state = HALTED;
            end
            if (can_enq) begin
                sb.push_back('{instr: instr, pc: m_pc, len: len});
                if (instr[7:0] == 8'hE9) begin
                    m_pc = m_pc + 32'd5 + instr[39:8];
                end else if (instr[7:0] == 8'hF4) begin
                    m_state = DRAIN;
                end else begin
                    m_pc = m_pc + {29'd0, len};
                end
            end
        end
        @(posedge clk);
        #1;
        check_val("fs_pc", {32'd0, bus.fs_pc}, {32'd0, m_pc});
        check_val("dec_valid", {63'd0, bus.dec_valid}, {63'd0, sb.size() > 0});
        check_val("halted", {63'd0, bus.halted}, {63'd0, m_state == HALTED});
        check_val("stall_cnt", {48'd0, bus.stall_cnt}, {48'd0, m_stall});
    endtask

    logic [2:0]  seq_len [4] = '{3'd2, 3'd3, 3'd5, 3'd1};
    logic [31:0] seq_pc  [4] = '{32'd2, 32'd5, 32'd10, 32'd11};
    logic [39:0] jmp_instr;
    logic [39:0] hlt_instr;

    initial begin
        jmp_instr        = 40'hFFFF_FFF0_E9;
        hlt_instr        = {32'd0, 8'hF4};
        bus.fs_instr     = 40'd0;
        bus.fs_length    = 3'd0;
        bus.dec_ready    = 1'b0;
        bus.redir_valid  = 1'b0;
        bus.redir_target = 32'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_fs_pc", {32'd0, bus.fs_pc}, 64'd0);
        check_val("rst_dec_valid", {63'd0, bus.dec_valid}, 64'd0);
        check_val("rst_dec_pc", {32'd0, bus.dec_pc}, 64'd0);
        check_val("rst_dec_instr", {24'd0, bus.dec_instr}, 64'd0);
        check_val("rst_dec_length", {61'd0, bus.dec_length}, 64'd0);
        check_val("rst_halted", {63'd0, bus.halted}, 64'd0);
        check_val("rst_stall", {48'd0, bus.stall_cnt}, 64'd0);
        rst = 1'b1;

        for (int i = 0; i < 4; i++) begin
            step(plain(seq_len[i]), seq_len[i], 1'b1, 1'b0, 32'd0);
            check_val("seq_pc", {32'd0, bus.fs_pc}, {32'd0, seq_pc[i]});
        end

        step(plain(3'd1), 3'd1, 1'b1, 1'b1, 32'h200);
        for (int i = 0; i < 4; i++) step(plain(3'd4), 3'd4, 1'b0, 1'b0, 32'd0);
        check_val("bp_pc_frozen", {32'd0, bus.fs_pc}, 64'h208);
        check_val("bp_stall", {48'd0, bus.stall_cnt}, 64'd2);
        check_val("bp_head_pc", {32'd0, bus.dec_pc}, 64'h200);

        step(plain(3'd1), 3'd1, 1'b1, 1'b1, 32'h4000);
        check_val("redir_dec_valid", {63'd0, bus.dec_valid}, 64'd0);
        check_val("redir_fs_pc", {32'd0, bus.fs_pc}, 64'h4000);

        step(plain(3'd1), 3'd1, 1'b1, 1'b1, 32'h100);
        step(jmp_instr, 3'd5, 1'b1, 1'b0, 32'd0);
        check_val("jmp_fs_pc", {32'd0, bus.fs_pc}, 64'hF5);
        check_val("jmp_dec_pc", {32'd0, bus.dec_pc}, 64'h100);
        check_val("jmp_dec_len", {61'd0, bus.dec_length}, 64'd5);
        step(plain(3'd2), 3'd2, 1'b1, 1'b0, 32'd0);

        step(plain(3'd2), 3'd2, 1'b0, 1'b1, 32'h1E);
        step(plain(3'd2), 3'd2, 1'b0, 1'b0, 32'd0);
        step(hlt_instr, 3'd1, 1'b0, 1'b0, 32'd0);
        step(plain(3'd1), 3'd1, 1'b0, 1'b0, 32'd0);
        check_val("drain_pc", {32'd0, bus.fs_pc}, 64'h20);
        #3;
        rst = 1'b0;
        #1;
        check_val("arst_fs_pc", {32'd0, bus.fs_pc}, 64'd0);
        check_val("arst_dec_valid", {63'd0, bus.dec_valid}, 64'd0);
        check_val("arst_halted", {63'd0, bus.halted}, 64'd0);
        check_val("arst_stall", {48'd0, bus.stall_cnt}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();

        step(plain(3'd2), 3'd2, 1'b0, 1'b1, 32'h1E);
        step(plain(3'd2), 3'd2, 1'b0, 1'b0, 32'd0);
        step(hlt_instr, 3'd1, 1'b0, 1'b0, 32'd0);
        check_val("hlt_pc_held", {32'd0, bus.fs_pc}, 64'h20);
        step(plain(3'd1), 3'd1, 1'b1, 1'b0, 32'd0);
        check_val("hlt_not_yet", {63'd0, bus.halted}, 64'd0);
        step(plain(3'd1), 3'd1, 1'b1, 1'b0, 32'd0);
        check_val("hlt_halted", {63'd0, bus.halted}, 64'd1);
        step(plain(3'd1), 3'd1, 1'b1, 1'b1, 32'h999);
        check_val("halt_redir_pc", {32'd0, bus.fs_pc}, 64'h20);
        check_val("halt_redir_halted", {63'd0, bus.halted}, 64'd1);
        check_val("halt_dec_valid", {63'd0, bus.dec_valid}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
